// File: rtl/fetch_unit_if.sv
// Address and cache-response bundles shared by the fetch stage and the instruction cache.
// ADDR_WIDTH / DATA_WIDTH default to 26 / 32 bits unless defined by the build.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface pc_ifc;
   logic [`ADDR_WIDTH-1:0] pc;
   modport out (output pc);
   modport in  (input  pc);
endinterface

interface cache_output_ifc;
   logic                   valid;
   logic [`DATA_WIDTH-1:0] data;
   modport out (output valid, data);
   modport in  (input  valid, data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, steers the cache index and queues hits for decode.
// Optional macro FETCH_BYPASS_EN forwards a hit straight to decode when the queue is empty.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_unit #(
   parameter logic [`ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                     QUEUE_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pc_ifc.out                     o_pc_current,
   pc_ifc.out                     o_pc_next,
   cache_output_ifc.in            i_cache,
   input  logic                   i_redirect_valid,
   input  logic [`ADDR_WIDTH-1:0] i_redirect_pc,
   output logic                   o_insn_valid,
   output logic [`DATA_WIDTH-1:0] o_insn,
   output logic [`ADDR_WIDTH-1:0] o_insn_pc,
   input  logic                   i_insn_ready,
   output logic                   o_fetch_stall
);

   localparam int AW    = `ADDR_WIDTH;
   localparam int DW    = `DATA_WIDTH;
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

   logic [AW-1:0]    pc_q, pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DW-1:0]    insn_mem_q [QUEUE_DEPTH];
   logic [DW-1:0]    insn_mem_d [QUEUE_DEPTH];
   logic [AW-1:0]    pc_mem_q   [QUEUE_DEPTH];
   logic [AW-1:0]    pc_mem_d   [QUEUE_DEPTH];

   logic          head_valid;
   logic          fifo_pop;
   logic          fifo_push;
   logic          space;
   logic          accept;
   logic [AW-1:0] redirect_pc_aligned;
   logic [AW-1:0] pc_plus4;
   logic [1:0]    redirect_lsb_unused;

   assign redirect_lsb_unused = i_redirect_pc[1:0];
   assign redirect_pc_aligned = {i_redirect_pc[AW-1:2], 2'b00};
   assign pc_plus4            = pc_q + AW'(4);

`ifdef FETCH_BYPASS_EN
   logic bypass_hit;

   always_comb begin
      head_valid = (count_q != '0);
      fifo_pop   = head_valid & i_insn_ready;
      space      = (count_q < DEPTH_C) | fifo_pop;
      accept     = i_cache.valid & space & ~i_redirect_valid;
      // Empty queue always has space, so this term is free of any ready dependence.
      bypass_hit = ~head_valid & i_cache.valid & ~i_redirect_valid;
      fifo_push  = accept & ~(bypass_hit & i_insn_ready);
      o_insn_valid = head_valid | bypass_hit;
      o_insn       = bypass_hit ? i_cache.data : insn_mem_q[rd_ptr_q];
      o_insn_pc    = bypass_hit ? pc_q         : pc_mem_q[rd_ptr_q];
   end
`else
   always_comb begin
      head_valid   = (count_q != '0);
      fifo_pop     = head_valid & i_insn_ready;
      space        = (count_q < DEPTH_C) | fifo_pop;
      accept       = i_cache.valid & space & ~i_redirect_valid;
      fifo_push    = accept;
      o_insn_valid = head_valid;
      o_insn       = insn_mem_q[rd_ptr_q];
      o_insn_pc    = pc_mem_q[rd_ptr_q];
   end
`endif

   always_comb begin
      pc_d       = pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      insn_mem_d = insn_mem_q;
      pc_mem_d   = pc_mem_q;
      if (i_redirect_valid) begin
         // Redirect wins over everything this cycle, including a pending pop.
         pc_d     = redirect_pc_aligned;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (accept) begin
            pc_d = pc_plus4;
         end
         if (fifo_push) begin
            insn_mem_d[wr_ptr_q] = i_cache.data;
            pc_mem_d[wr_ptr_q]   = pc_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      end
   end

   assign o_pc_current.pc = pc_q;
   assign o_pc_next.pc    = pc_d;
   assign o_fetch_stall   = ~accept & ~i_redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            insn_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         insn_mem_q <= insn_mem_d;
         pc_mem_q   <= pc_mem_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based reference model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_fetch_unit;
   localparam int AW = `ADDR_WIDTH;
   localparam int DW = `DATA_WIDTH;
   localparam int DEPTH = 2;
   localparam logic [AW-1:0] RST_PC = 26'h100;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] insn;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          hit;
   logic [DW-1:0] hit_data;
   logic          redir;
   logic [AW-1:0] redir_pc;
   logic          ready;
   logic          insn_valid;
   logic [DW-1:0] insn;
   logic [AW-1:0] insn_pc;
   logic          stall;

   int n_checks = 0;
   int n_fail   = 0;

   pc_ifc           pc_cur_if ();
   pc_ifc           pc_nxt_if ();
   cache_output_ifc cache_if ();

   assign cache_if.valid = hit;
   assign cache_if.data  = hit_data;

   fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .o_pc_current     (pc_cur_if),
      .o_pc_next        (pc_nxt_if),
      .i_cache          (cache_if),
      .i_redirect_valid (redir),
      .i_redirect_pc    (redir_pc),
      .o_insn_valid     (insn_valid),
      .o_insn           (insn),
      .o_insn_pc        (insn_pc),
      .i_insn_ready     (ready),
      .o_fetch_stall    (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of {pc, insn} and a fetch address.
   ent_t          mq[$];
   logic [AW-1:0] mpc;

   always @(negedge clk) begin
      automatic bit            exp_valid;
      automatic bit            byp;
      automatic bit            pop;
      automatic bit            acc;
      automatic ent_t          head;
      automatic logic [AW-1:0] tgt;
      automatic logic [AW-1:0] exp_next;
      if (!rst_n) begin
         mq.delete();
         mpc = RST_PC;
         check("rst_pc_current", pc_cur_if.pc, RST_PC);
         check("rst_insn_valid", insn_valid, 0);
         check("rst_insn", insn, 0);
         check("rst_insn_pc", insn_pc, 0);
      end else begin
         tgt       = redir_pc & ~(AW'(3));
         exp_valid = (mq.size() > 0);
         byp       = 1'b0;
         head      = (mq.size() > 0) ? mq[0] : '0;
`ifdef FETCH_BYPASS_EN
         if (mq.size() == 0 && hit && !redir) begin
            exp_valid = 1'b1;
            byp       = 1'b1;
            head      = '{pc: mpc, insn: hit_data};
         end
`endif
         pop = exp_valid && ready;
         acc = hit && !redir && ((mq.size() < DEPTH) || pop);
         exp_next = redir ? tgt : (acc ? mpc + AW'(4) : mpc);
         check("m_pc_current", pc_cur_if.pc, mpc);
         check("m_pc_next", pc_nxt_if.pc, exp_next);
         check("m_insn_valid", insn_valid, exp_valid);
         check("m_stall", stall, !acc && !redir);
         if (exp_valid) begin
            check("m_insn", insn, head.insn);
            check("m_insn_pc", insn_pc, head.pc);
         end
         if (redir) begin
            mq.delete();
            mpc = tgt;
         end else begin
            if (pop && !byp) void'(mq.pop_front());
            if (acc && !(byp && ready)) mq.push_back('{pc: mpc, insn: hit_data});
            if (acc) mpc = mpc + AW'(4);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; hit = 1'b0; hit_data = '0; redir = 1'b0; redir_pc = '0; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #2;
      check("reset_pc_current", pc_cur_if.pc, 26'h100);
      check("reset_pc_next", pc_nxt_if.pc, 26'h100);
      check("reset_insn", insn, 0);
      check("reset_insn_pc", insn_pc, 0);
      check("reset_valid", insn_valid, 0);
      check("reset_stall", stall, 1);

      // Continuous hits, decode always ready.
      step(); hit = 1'b1; hit_data = $urandom;
      #2 check("first_hit_pc_next", pc_nxt_if.pc, 26'h104);
      for (int i = 0; i < 3; i++) begin
         step(); hit_data = $urandom;
         #2;
         check("stream_valid", insn_valid, 1);
         check("stream_insn_pc", insn_pc, 26'h100 + 26'(4 * i));
         check("stream_pc_next", pc_nxt_if.pc, 26'h108 + 26'(4 * i));
      end

      // Miss held at 0x200.
      step(); hit = 1'b0; redir = 1'b1; redir_pc = 26'h200;
      #2 check("redir_200_pc_next", pc_nxt_if.pc, 26'h200);
      step(); redir = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #2;
         check("miss_pc_current", pc_cur_if.pc, 26'h200);
         check("miss_pc_next", pc_nxt_if.pc, 26'h200);
         check("miss_stall", stall, 1);
         step();
      end
      hit = 1'b1; hit_data = $urandom;
      #2 check("miss_end_pc_next", pc_nxt_if.pc, 26'h204);
      step(); hit = 1'b0;
      #2;
      check("miss_end_pc_current", pc_cur_if.pc, 26'h204);
      check("miss_end_insn_pc", insn_pc, 26'h200);

      // Back-pressure fills the queue; then drain in order.
      step(); redir = 1'b1; redir_pc = 26'h300; ready = 1'b0;
      step(); redir = 1'b0; hit = 1'b1; hit_data = $urandom;
      repeat (3) begin step(); hit_data = $urandom; end
      #2;
      check("full_pc_current", pc_cur_if.pc, 26'h308);
      check("full_stall", stall, 1);
      step(); ready = 1'b1; hit = 1'b0;
      #2 check("drain0_insn_pc", insn_pc, 26'h300);
      step();
      #2 check("drain1_insn_pc", insn_pc, 26'h304);
      step();
      #2 check("drain_empty", insn_valid, 0);

      // Refill, then redirect to an unaligned target with the queue full.
      step(); ready = 1'b0; hit = 1'b1; hit_data = $urandom;
      repeat (2) begin step(); hit_data = $urandom; end
      step(); ready = 1'b1; redir = 1'b1; redir_pc = 26'h3FF;
      #2 check("unaligned_pc_next", pc_nxt_if.pc, 26'h3FC);
      step(); redir = 1'b0; hit = 1'b0;
      #2;
      check("post_redir_valid", insn_valid, 0);
      check("post_redir_pc_current", pc_cur_if.pc, 26'h3FC);
      step(); hit = 1'b1; hit_data = $urandom;
      step(); hit = 1'b0;
      #2 check("post_redir_insn_pc", insn_pc, 26'h3FC);

      // Address wrap.
      step(); redir = 1'b1; redir_pc = 26'h3FFFFFC;
      step(); redir = 1'b0; hit = 1'b1; hit_data = $urandom;
      #2 check("wrap_pc_next", pc_nxt_if.pc, 26'h0);
      step(); hit = 1'b0;
      #2;
      check("wrap_pc_current", pc_cur_if.pc, 26'h0);
      check("wrap_insn_pc", insn_pc, 26'h3FFFFFC);

      // Asynchronous reset in the middle of a miss.
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_pc_current", pc_cur_if.pc, 26'h100);
      check("async_rst_valid", insn_valid, 0);
      step(); rst_n = 1'b1;

      // Randomized traffic checked by the model.
      for (int c = 0; c < 3000; c++) begin
         step();
         rst_n    = 1'b1;
         hit      = ($urandom_range(9) < 7);
         hit_data = $urandom;
         ready    = ($urandom_range(9) < 6);
         redir    = ($urandom_range(19) == 0);
         redir_pc = AW'($urandom);
         if ($urandom_range(499) == 0) begin
            #2 rst_n = 1'b0;
         end
      end
      step(); rst_n = 1'b1; hit = 1'b0; redir = 1'b0;
      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the instruction cache. Owns the program counter, drives the current and next fetch addresses the cache needs for its synchronous-read banks, and captures hit data into a small FIFO that feeds decode through a valid/ready handshake. A redirect from later stages (branch or jump resolution) flushes in-flight state and restarts fetch at the new address.

## Interface
- RESET_PC, 0: byte address fetched after reset; bits [1:0] must be 0.
- QUEUE_DEPTH, 2: instruction FIFO entries; power of two, 2..8.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- o_pc_current  out  pc_ifc.out  address the cache looks up this cycle (`ADDR_WIDTH)
- o_pc_next  out  pc_ifc.out  address the cache must index on the coming edge (`ADDR_WIDTH)
- i_cache  in  cache_output_ifc.in  valid = hit for o_pc_current, data = instruction (`DATA_WIDTH)
- i_redirect_valid  in  1  restart fetch
- i_redirect_pc  in  `ADDR_WIDTH  restart address
- o_insn_valid  out  1  FIFO head valid
- o_insn  out  `DATA_WIDTH  FIFO head instruction
- o_insn_pc  out  `ADDR_WIDTH  FIFO head byte address
- i_insn_ready  in  1  decode consumes head when valid & ready
- o_fetch_stall  out  1  cache valid but not accepted, or cache not valid (performance counter input)

## Operation
- State: pc register, FIFO storage {pc, insn} × QUEUE_DEPTH, read/write pointers of log2(QUEUE_DEPTH) bits, count of log2(QUEUE_DEPTH)+1 bits.
- o_pc_current.pc = pc register.
- pop = o_insn_valid & i_insn_ready.
- space = (count < QUEUE_DEPTH) | pop.
- accept = i_cache.valid & space & ~i_redirect_valid.
- On accept: write {pc, i_cache.data} at write pointer; pc <= pc + 4.
- Priority: redirect > accept > hold.
- o_pc_next.pc (combinational):
  - i_redirect_valid: {i_redirect_pc[`ADDR_WIDTH-1:2], 2'b00}
  - accept: pc + 4
  - otherwise: pc
- Redirect: pc <= aligned i_redirect_pc; count, pointers <= 0; the same cycle's pop and cache data are discarded. Bits [1:0] of i_redirect_pc are ignored.
- pc + 4 wraps modulo 2^`ADDR_WIDTH; pointers wrap modulo QUEUE_DEPTH.
- Cache miss (i_cache.valid=0): pc held, o_pc_next = pc, so the cache re-reads the same line after refill.
- Full FIFO with pop and hit in the same cycle: push and pop both occur; count is unchanged.
- Empty FIFO: o_insn_valid=0; o_insn and o_insn_pc hold the stale head entry, and decode ignores them.
- o_fetch_stall = ~accept & ~i_redirect_valid.

## Timing
- Reset values:
  - pc = RESET_PC; o_pc_current.pc = o_pc_next.pc = RESET_PC.
  - count = 0; o_insn_valid = 0.
  - FIFO storage = 0, so o_insn = 0 and o_insn_pc = 0.
  - o_fetch_stall = 1 while i_cache.valid = 0.
- Reset asserted mid-operation takes effect immediately and asynchronously; any outstanding miss is abandoned, and the cache reissues from RESET_PC.
- Hit latency: cache hit in cycle N → entry visible on o_insn in cycle N+1.
- Steady state: one instruction per cycle when hits continue and decode is ready.
- Redirect in cycle N: o_pc_next = target in cycle N; o_pc_current = target in N+1; the first target instruction appears on o_insn no earlier than N+2.
- o_insn_valid depends only on registered state; there is no combinational path from i_insn_ready to o_insn_valid.

## Configuration
- FETCH_BYPASS_EN:
  - Defined: when count=0 and accept, o_insn_valid=1 in the same cycle, with o_insn = i_cache.data and o_insn_pc = pc. If i_insn_ready is also 1, the entry is consumed and not written into the FIFO. Hit-to-decode latency becomes 0 cycles.
  - Undefined: no bypass; behaviour as in Timing (latency 1).

## Test plan
- Reset with RESET_PC=0x100, cache always valid, ready=1 → o_insn_pc sequence 0x100, 0x104, 0x108 on consecutive cycles starting 1 cycle after first hit; o_pc_next leads o_pc_current by 4.
- Cache invalid for 5 cycles at pc=0x200 → o_pc_current and o_pc_next hold 0x200; o_fetch_stall=1; no push; on hit, pc advances to 0x204.
- ready=0 with continuous hits, QUEUE_DEPTH=2 → count reaches 2, pc stops at base+8; raise ready → entries drain in order, one per cycle, with no duplicates or losses.
- Redirect to 0x3FF (unaligned) while FIFO holds 2 entries and ready=1 → o_pc_next=0x3FC same cycle; o_insn_valid=0 next cycle; next delivered o_insn_pc=0x3FC.
- pc=2^`ADDR_WIDTH-4 hit → pc wraps to 0; entry pc reported as 0x3FFFFFC for 26-bit addresses.
- Assert rst_n low mid-miss, asynchronously → o_insn_valid=0 and o_pc_current=RESET_PC before the next clk edge.
